// File: rtl/VX_gpu_pkg.sv
// ----------------------------------------------------------------------------
// VX_gpu_pkg
//   Shared type and constant definitions for the vector operand sequencer:
//   register-file geometry, the scoreboard-to-operand-collector data struct,
//   the LMUL encoding and a clamp helper for the group-size field.
// ----------------------------------------------------------------------------
package VX_gpu_pkg;

    localparam int NUM_THREADS    = 4;
    localparam int NW_BITS        = 2;
    localparam int NR_BITS        = 6;
    localparam int PC_BITS        = 32;
    localparam int EX_BITS        = 2;
    localparam int INST_OP_BITS   = 4;
    localparam int INST_ARGS_BITS = 8;
    localparam int UUID_WIDTH     = 16;
    localparam int PERF_CTR_BITS  = 44;

    // LMUL is carried as log2 of the register-group size.
    localparam int LMUL_BITS = 3;
    localparam logic [LMUL_BITS-1:0] LMUL_1 = 3'd0;
    localparam logic [LMUL_BITS-1:0] LMUL_2 = 3'd1;
    localparam logic [LMUL_BITS-1:0] LMUL_4 = 3'd2;
    localparam logic [LMUL_BITS-1:0] LMUL_8 = 3'd3;

    typedef struct packed {
        logic [NW_BITS-1:0]        wis;
        logic [NUM_THREADS-1:0]    tmask;
        logic [PC_BITS-1:0]        PC;
        logic                      wb;
        logic [EX_BITS-1:0]        ex_type;
        logic [INST_OP_BITS-1:0]   op_type;
        logic [INST_ARGS_BITS-1:0] op_args;
        logic [NR_BITS-1:0]        rd;
        logic [NR_BITS-1:0]        rs1;
        logic [NR_BITS-1:0]        rs2;
        logic [NR_BITS-1:0]        rs3;
        logic [UUID_WIDTH-1:0]     uuid;
    } scoreboard_data_t;

    // Oversized group requests collapse to the largest supported group.
    function automatic logic [LMUL_BITS-1:0] lmul_clamp(
        input logic [LMUL_BITS-1:0] lmul,
        input logic [LMUL_BITS-1:0] max_log2
    );
        return (lmul > max_log2) ? max_log2 : lmul;
    endfunction

endpackage

// File: rtl/vx_vector_opd_sequencer.sv
// ----------------------------------------------------------------------------
// vx_vector_opd_sequencer
//   Expands one vector instruction from the scoreboard into 2^lmul per-beat
//   micro-ops for the operand collector. Each beat carries the latched
//   instruction with rd/rs1/rs2/rs3 advanced by the beat index; register 0
//   is a "no operand" marker and is never advanced.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   in_valid/ready: instruction handshake from the scoreboard
//   in_data       : scoreboard data struct
//   in_lmul       : log2 group size (clamped to MAX_LMUL_LOG2)
//   out_valid/ready: micro-op handshake toward the operand collector
//   out_data      : per-beat micro-op
//   out_beat      : beat index within the group
//   out_sop/eop   : first / last beat of the group
//   busy          : a group is in flight
//   perf_stalls   : cycles with in_valid held off (zero when PERF_ENABLE=0)
// ----------------------------------------------------------------------------
module vx_vector_opd_sequencer
    import VX_gpu_pkg::*;
#(
    parameter            INSTANCE_ID   = "",
    parameter int        MAX_LMUL_LOG2 = 3,
    parameter bit        PERF_ENABLE   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  scoreboard_data_t         in_data,
    input  logic [LMUL_BITS-1:0]     in_lmul,
    output logic                     out_valid,
    input  logic                     out_ready,
    output scoreboard_data_t         out_data,
    output logic [MAX_LMUL_LOG2-1:0] out_beat,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic                     busy,
    output logic [PERF_CTR_BITS-1:0] perf_stalls
);

    localparam int BEAT_W = MAX_LMUL_LOG2;
    localparam logic [LMUL_BITS-1:0] MAX_LMUL = LMUL_BITS'(MAX_LMUL_LOG2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    state_t              r_state;
    scoreboard_data_t    r_data;
    logic [LMUL_BITS-1:0] r_lmul;
    logic [BEAT_W-1:0]   r_beat;

    logic [BEAT_W-1:0]   w_beat_last;
    logic                w_in_fire;
    logic                w_out_fire;

    // The instance name only labels traces; keep it referenced.
    logic                w_unused_instance_id;
    assign w_unused_instance_id = ($bits(INSTANCE_ID) > 0);

    // Register index for a given beat: base+beat with silent wrap, except
    // that base 0 means "no operand" and stays 0.
    function automatic logic [NR_BITS-1:0] beat_reg(
        input logic [NR_BITS-1:0] base,
        input logic [BEAT_W-1:0]  beat
    );
        if (base == '0) begin
            return '0;
        end
        return base + NR_BITS'(beat);
    endfunction

    assign w_beat_last = BEAT_W'((32'd1 << r_lmul) - 32'd1);

    assign out_valid  = (r_state == ST_SEQ);
    assign busy       = (r_state == ST_SEQ);
    assign out_beat   = r_beat;
    assign out_sop    = (r_beat == '0);
    assign out_eop    = (r_beat == w_beat_last);

    // Accepting on the last beat's handshake lets groups run back-to-back.
    assign w_out_fire = out_valid && out_ready;
    assign in_ready   = (r_state == ST_IDLE) || (w_out_fire && out_eop);
    assign w_in_fire  = in_valid && in_ready;

    always_comb begin
        out_data     = r_data;
        out_data.rd  = beat_reg(r_data.rd,  r_beat);
        out_data.rs1 = beat_reg(r_data.rs1, r_beat);
        out_data.rs2 = beat_reg(r_data.rs2, r_beat);
        out_data.rs3 = beat_reg(r_data.rs3, r_beat);
    end

    // Control: FSM and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else if (w_in_fire) begin
            r_state <= ST_SEQ;
            r_beat  <= '0;
        end else if (w_out_fire) begin
            if (out_eop) begin
                r_state <= ST_IDLE;
                r_beat  <= '0;
            end else begin
                r_beat  <= r_beat + BEAT_W'(1);
            end
        end
    end

    // Instruction payload; only meaningful while in SEQ, so not reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_data <= in_data;
            r_lmul <= lmul_clamp(in_lmul, MAX_LMUL);
        end
    end

    generate
        if (PERF_ENABLE) begin : g_perf
            logic [PERF_CTR_BITS-1:0] r_perf_stalls;

            // Free-running wrap is intended; the counter never saturates.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_perf_stalls <= '0;
                end else if (in_valid && !in_ready) begin
                    r_perf_stalls <= r_perf_stalls + PERF_CTR_BITS'(1);
                end
            end

            assign perf_stalls = r_perf_stalls;
        end else begin : g_no_perf
            assign perf_stalls = '0;
        end
    endgenerate

endmodule

// File: tb/tb_vx_vector_opd_sequencer.sv
module tb_vx_vector_opd_sequencer;
    import VX_gpu_pkg::*;

    localparam int MAXL = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    scoreboard_data_t         in_data;
    logic [LMUL_BITS-1:0]     in_lmul;
    logic                     out_valid;
    logic                     out_ready;
    scoreboard_data_t         out_data;
    logic [MAXL-1:0]          out_beat;
    logic                     out_sop;
    logic                     out_eop;
    logic                     busy;
    logic [PERF_CTR_BITS-1:0] perf_stalls;

    always #5 clk = ~clk;

    vx_vector_opd_sequencer #(
        .INSTANCE_ID   ("tb_seq"),
        .MAX_LMUL_LOG2 (MAXL),
        .PERF_ENABLE   (1'b1)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_lmul     (in_lmul),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_beat    (out_beat),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .busy        (busy),
        .perf_stalls (perf_stalls)
    );

    typedef struct {
        scoreboard_data_t d;
        logic [MAXL-1:0]  beat;
        logic             sop;
        logic             eop;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic scoreboard_data_t mk(input int rd, input int rs1, input int rs2,
                                            input int rs3, input int id);
        scoreboard_data_t d;
        d.wis     = NW_BITS'(id);
        d.tmask   = 4'hA;
        d.PC      = 32'h8000_0000 + 32'(id * 4);
        d.wb      = 1'b1;
        d.ex_type = 2'd2;
        d.op_type = 4'h5;
        d.op_args = 8'(8'h3C + id);
        d.rd      = NR_BITS'(rd);
        d.rs1     = NR_BITS'(rs1);
        d.rs2     = NR_BITS'(rs2);
        d.rs3     = NR_BITS'(rs3);
        d.uuid    = 16'(id);
        return d;
    endfunction

    task automatic push(input scoreboard_data_t t, input int beat, input int sop, input int eop,
                        input int rd, input int rs1, input int rs2, input int rs3);
        exp_t e;
        e.d     = t;
        e.d.rd  = NR_BITS'(rd);
        e.d.rs1 = NR_BITS'(rs1);
        e.d.rs2 = NR_BITS'(rs2);
        e.d.rs3 = NR_BITS'(rs3);
        e.beat  = MAXL'(beat);
        e.sop   = (sop != 0);
        e.eop   = (eop != 0);
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input scoreboard_data_t act,
                            input scoreboard_data_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic issue(input scoreboard_data_t d, input logic [LMUL_BITS-1:0] l);
        int k;
        k        = 0;
        in_data  = d;
        in_lmul  = l;
        in_valid = 1'b1;
        while (!in_ready && k < 64) begin
            step();
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: in_ready=%0d after %0d cycles, required 1", in_ready, k);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 64) begin
            step();
            k++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0d after %0d cycles, required 0", busy, k);
        end
    endtask

    // Monitor: every accepted micro-op is checked against the next expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: beat=%0d rs1=%0d data=%h, required no output",
                         out_beat, out_data.rs1, out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_data !== e.d || out_beat !== e.beat ||
                    out_sop !== e.sop || out_eop !== e.eop) begin
                    n_err++;
                    $display("FAIL beat_compare: got beat=%0d sop=%0d eop=%0d rd=%0d rs1=%0d rs2=%0d rs3=%0d data=%h, required beat=%0d sop=%0d eop=%0d rd=%0d rs1=%0d rs2=%0d rs3=%0d data=%h",
                             out_beat, out_sop, out_eop, out_data.rd, out_data.rs1,
                             out_data.rs2, out_data.rs3, out_data,
                             e.beat, e.sop, e.eop, e.d.rd, e.d.rs1, e.d.rs2, e.d.rs3, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        scoreboard_data_t         a;
        scoreboard_data_t         b;
        scoreboard_data_t         snap;
        logic [PERF_CTR_BITS-1:0] p0;
        int                       wrap_rs1 [8];

        wrap_rs1  = '{62, 63, 0, 1, 2, 3, 4, 5};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_lmul   = '0;
        out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_beat", 64'(out_beat), 64'd0);
        chk("rst_perf", 64'(perf_stalls), 64'd0);
        reset = 1'b0;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single-beat group (lmul=0)
        a = mk(3, 5, 0, 0, 1);
        push(a, 0, 1, 1, 3, 5, 0, 0);
        issue(a, 3'd0);
        chk("s1_valid_lat1", 64'(out_valid), 64'd1);
        chk("s1_busy", 64'(busy), 64'd1);
        chk("s1_sop", 64'(out_sop), 64'd1);
        chk("s1_eop", 64'(out_eop), 64'd1);
        step();
        chk("s1_busy_after", 64'(busy), 64'd0);
        chk("s1_valid_after", 64'(out_valid), 64'd0);

        // Four-beat group; rs3=0 must stay 0
        a = mk(24, 8, 16, 0, 2);
        for (int i = 0; i < 4; i++) push(a, i, int'(i == 0), int'(i == 3), 24 + i, 8 + i, 16 + i, 0);
        issue(a, 3'd2);
        wait_idle();

        // Back-pressure at beat 1 for 3 cycles with a pending instruction
        a = mk(40, 1, 2, 3, 3);
        b = mk(0, 0, 0, 0, 4);
        for (int i = 0; i < 4; i++) push(a, i, int'(i == 0), int'(i == 3), 40 + i, 1 + i, 2 + i, 3 + i);
        push(b, 0, 1, 1, 0, 0, 0, 0);
        issue(a, 3'd2);
        step();
        out_ready = 1'b0;
        in_data   = b;
        in_lmul   = 3'd0;
        in_valid  = 1'b1;
        snap      = out_data;
        p0        = perf_stalls;
        chk("s3_beat_start", 64'(out_beat), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s3_beat_hold", 64'(out_beat), 64'd1);
            chk_data("s3_data_hold", out_data, snap);
            chk("s3_in_ready_low", 64'(in_ready), 64'd0);
            chk("s3_valid_hold", 64'(out_valid), 64'd1);
        end
        chk("s3_perf_plus3", 64'(perf_stalls), 64'(p0 + 44'd3));
        out_ready = 1'b1;
        issue(b, 3'd0);
        wait_idle();

        // Two lmul=1 groups back-to-back
        a = mk(10, 20, 30, 0, 5);
        b = mk(50, 60, 0, 33, 6);
        push(a, 0, 1, 0, 10, 20, 30, 0);
        push(a, 1, 0, 1, 11, 21, 31, 0);
        push(b, 0, 1, 0, 50, 60, 0, 33);
        push(b, 1, 0, 1, 51, 61, 0, 34);
        issue(a, 3'd1);
        in_data  = b;
        in_lmul  = 3'd1;
        in_valid = 1'b1;
        chk("s4_in_ready_beat0", 64'(in_ready), 64'd0);
        step();
        chk("s4_in_ready_at_eop", 64'(in_ready), 64'd1);
        chk("s4_eop", 64'(out_eop), 64'd1);
        step();
        in_valid = 1'b0;
        chk("s4_no_gap_valid", 64'(out_valid), 64'd1);
        chk("s4_no_gap_beat", 64'(out_beat), 64'd0);
        chk("s4_no_gap_rs1", 64'(out_data.rs1), 64'd60);
        wait_idle();

        // Register index wrap (lmul=3, rs1=62)
        a = mk(7, 62, 0, 0, 7);
        for (int i = 0; i < 8; i++) push(a, i, int'(i == 0), int'(i == 7), 7 + i, wrap_rs1[i], 0, 0);
        issue(a, 3'd3);
        wait_idle();

        // lmul above maximum is clamped to 8 beats
        a = mk(3, 1, 50, 0, 8);
        for (int i = 0; i < 8; i++) push(a, i, int'(i == 0), int'(i == 7), 3 + i, 1 + i, 50 + i, 0);
        issue(a, 3'd6);
        wait_idle();

        // Reset at beat 2 of an 8-beat group
        a = mk(9, 4, 0, 0, 9);
        push(a, 0, 1, 0, 9, 4, 0, 0);
        push(a, 1, 0, 0, 10, 5, 0, 0);
        issue(a, 3'd3);
        step();
        step();
        chk("s7_at_beat2", 64'(out_beat), 64'd2);
        out_ready = 1'b0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        chk("s7_valid_after_rst", 64'(out_valid), 64'd0);
        chk("s7_busy_after_rst", 64'(busy), 64'd0);
        chk("s7_beat_after_rst", 64'(out_beat), 64'd0);
        chk("s7_in_ready_after_rst", 64'(in_ready), 64'd1);
        step();
        chk("s7_no_more_beats", 64'(out_valid), 64'd0);
        b = mk(11, 12, 13, 14, 10);
        push(b, 0, 1, 0, 11, 12, 13, 14);
        push(b, 1, 0, 1, 12, 13, 14, 15);
        issue(b, 3'd1);
        chk("s7_restart_beat", 64'(out_beat), 64'd0);
        chk("s7_restart_sop", 64'(out_sop), 64'd1);
        wait_idle();

        step();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vx_vector_opd_sequencer.md
VX_VECTOR_OPD_SEQUENCER -- requirements
Module: VX_vector_opd_sequencer

Interface
REQ-001 SHALL have parameter INSTANCE_ID, default "", used for debug/trace naming only.
REQ-002 SHALL have parameter MAX_LMUL_LOG2, default 3, giving the maximum register-group size 2^MAX_LMUL_LOG2 beats.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  the instruction from the scoreboard is valid.
REQ-006 SHALL have port in_ready  output  1  the sequencer accepts the instruction.
REQ-007 SHALL have port in_data  input  scoreboard data struct  wis, tmask, PC, wb, ex_type, op_type, op_args, rd, rs1, rs2, rs3, uuid.
REQ-008 SHALL have port in_lmul  input  LMUL_BITS  log2 of the group size; values above MAX_LMUL_LOG2 are clamped to MAX_LMUL_LOG2.
REQ-009 SHALL have port out_valid  output  1  the micro-op toward the operand collector is valid.
REQ-010 SHALL have port out_ready  input  1  the operand collector accepts the micro-op.
REQ-011 SHALL have port out_data  output  scoreboard data struct  the per-beat micro-op.
REQ-012 SHALL have port out_beat  output  MAX_LMUL_LOG2  the beat index.
REQ-013 SHALL have port out_sop  output  1  marks the first beat of a group.
REQ-014 SHALL have port out_eop  output  1  marks the last beat of a group.
REQ-015 SHALL have port busy  output  1  a group is in flight.
REQ-016 SHALL have port perf_stalls  output  PERF_CTR_BITS  the input stall count; present only under PERF_ENABLE.

Function
REQ-017 SHALL run a two-state FSM, IDLE and SEQ; busy SHALL be 1 exactly in SEQ.
REQ-018 SHALL drive in_ready = (state==IDLE) || (out_valid && out_ready && out_eop), giving back-to-back groups with no bubble.
REQ-019 On an in fire, SHALL latch in_data and the clamped lmul, set beat=0, and enter SEQ; out_valid SHALL assert the next cycle (latency 1).
REQ-020 In SEQ, out_valid SHALL be 1; out_data SHALL hold the latched fields unchanged except rd, rs1, rs2 and rs3.
REQ-021 Each of rd/rs1/rs2/rs3 SHALL output base+beat modulo 2^NR_BITS (wraps silently).
REQ-022 A base register index of 0 SHALL stay 0 on every beat (no-operand marker).
REQ-023 out_sop SHALL be (beat==0); out_eop SHALL be (beat==2^lmul-1).
REQ-024 When lmul=0, the group SHALL be a single beat with out_sop=out_eop=1.
REQ-025 On out fire without out_eop, beat SHALL increment by 1; with out_valid && ~out_ready, all outputs SHALL hold stable.
REQ-026 On out fire with out_eop and no simultaneous in fire, the FSM SHALL return to IDLE and out_valid SHALL be 0 the next cycle.
REQ-027 On out fire with out_eop and a simultaneous in fire, the FSM SHALL stay in SEQ with the new instruction at beat 0 the next cycle.
REQ-028 perf_stalls SHALL increment by 1 each cycle with in_valid && ~in_ready and SHALL not saturate (wraps).

Reset
REQ-029 Reset SHALL force IDLE, out_valid=0, busy=0, beat=0 and perf_stalls=0; in_ready SHALL be 1 the cycle after reset deasserts.
REQ-030 Reset mid-group SHALL discard remaining beats with no further out_valid.
REQ-031 Latched data registers need not be reset.

Structure
REQ-032 LMUL_BITS and the lmul encoding constants SHALL be defined in VX_gpu_pkg.
REQ-033 No sub-module SHALL be used; the FSM, beat counter, index adders and output register SHALL be inline.

Verification
REQ-034 Scenario: lmul=0, rs1=5, rs2=0, rs3=0, out_ready=1 -> one beat at T+1 with rs1=5, rs2=0, sop=eop=1; busy=0 at T+2.
REQ-035 Scenario: lmul=2, rs1=8, rs2=16, rd=24 -> 4 beats with rs1=8..11, rs2=16..19, rd=24..27, beat=0..3; sop only on beat 0, eop only on beat 3.
REQ-036 Scenario: out_ready held 0 for 3 cycles mid-group at beat 1 -> beat 1 and out_data stable for all 3 cycles; in_ready=0 throughout; perf_stalls +3 while in_valid=1.
REQ-037 Scenario: two lmul=1 instructions presented back-to-back -> beats 0,1,0,1 on consecutive cycles with no gap; the second is accepted in the same cycle as the first group's eop.
REQ-038 Scenario: lmul=3 with rs1=2^NR_BITS-2 -> rs1 sequence is 2^NR_BITS-2, 2^NR_BITS-1, 0, 1, ...
REQ-039 Scenario: reset asserted at beat 2 of an lmul=3 group -> out_valid=0 the next cycle, IDLE, and the next instruction starts at beat 0.
